// File: rtl/fetch_queue_if.sv
// Handshake bundle between the PC fetch stage, the prefetch queue and decode.
// The master side is the fetch/decode environment; the slave side is the queue.
interface fetch_queue_if #(
   parameter int DEPTH       = 4,
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 32
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PC_WIDTH-1:0]    pcIn;
   logic [INSTR_WIDTH-1:0] instrIn;
   logic                   inValid;
   logic                   flush;
   logic                   deqReady;
   logic [PC_WIDTH-1:0]    pcOut;
   logic [INSTR_WIDTH-1:0] instrOut;
   logic                   outValid;
   logic                   notEnable;
   logic [CNT_W-1:0]       count;

   modport master (
      output pcIn, instrIn, inValid, flush, deqReady,
      input  pcOut, instrOut, outValid, notEnable, count
   );

   modport slave (
      input  pcIn, instrIn, inValid, flush, deqReady,
      output pcOut, instrOut, outValid, notEnable, count
   );

endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: buffers (pc, instruction) pairs from the fetch
// register in FIFO order, shows the oldest pair to decode without a read
// cycle, stalls the PC register when it cannot accept, and empties on flush.
// All state changes on the falling clock edge.
module fetch_queue #(
   parameter int DEPTH       = 4,
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 32
) (
   input logic          clock,
   input logic          reset,
   fetch_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PC_WIDTH-1:0]    pcMem    [DEPTH];
   logic [INSTR_WIDTH-1:0] instrMem [DEPTH];
   logic [PTR_W-1:0]       wrPtr;
   logic [PTR_W-1:0]       rdPtr;
   logic [CNT_W-1:0]       count;

   logic notEmpty;
   logic full;
   logic deq;
   logic enq;

   // Occupancy lives in its own counter, so full and empty never alias even
   // though both pointers wrap modulo DEPTH. A write is allowed while full only
   // when the head leaves in the same cycle; flush suppresses any write.
   always_comb begin
      notEmpty = (count != '0);
      full     = (count == FULL_CNT);
      deq      = notEmpty & bus.deqReady;
      enq      = bus.inValid & (~full | deq) & ~bus.flush;
   end

   // Head entry falls through to decode; an empty queue reads as all zeros so
   // stale storage left behind by a flush is never visible. The stall only
   // holds the PC when the queue is full and decode is not freeing a slot.
   always_comb begin
      bus.outValid  = notEmpty;
      bus.pcOut     = notEmpty ? pcMem[rdPtr]    : '0;
      bus.instrOut  = notEmpty ? instrMem[rdPtr] : '0;
      bus.notEnable = full & ~bus.deqReady;
      bus.count     = count;
   end

   // Storage, pointers and occupancy. Reset wipes everything immediately;
   // flush only rewinds pointers and count, since the empty rule already
   // masks whatever data remains in storage. Simultaneous enqueue and dequeue
   // leave the count unchanged, which is what lets a full queue stream.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pcMem[i]    <= '0;
            instrMem[i] <= '0;
         end
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (bus.flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            pcMem[wrPtr]    <= bus.pcIn;
            instrMem[wrPtr] <= bus.instrIn;
            wrPtr           <= wrPtr + PTR_ONE;
         end
         if (deq) begin
            rdPtr <= rdPtr + PTR_ONE;
         end
         case ({enq, deq})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch queue sitting directly downstream of the PC fetch register; consumes its registered PC plus the instruction word read from instruction memory at that PC.
- Buffers up to DEPTH (pc, instruction) pairs in FIFO order and presents the oldest pair to decode (first-word-fall-through).
- Back-pressures the PC register through an active-high stall (notEnable) when it cannot accept; discards all contents on a branch/jump flush.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PC_WIDTH, 8, width of the stored PC.
- INSTR_WIDTH, 32, width of the stored instruction word.

Ports:
- clock  in  1  single system clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- pcIn  in  PC_WIDTH  PC from the fetch register output.
- instrIn  in  INSTR_WIDTH  instruction memory data for pcIn.
- inValid  in  1  pcIn/instrIn hold a real fetch this cycle.
- flush  in  1  discard all queued and incoming entries (taken branch/jump).
- deqReady  in  1  decode accepts the head entry this cycle.
- pcOut  out  PC_WIDTH  PC of the head entry.
- instrOut  out  INSTR_WIDTH  instruction of the head entry.
- outValid  out  1  head entry is valid.
- notEnable  out  1  stall to the PC register; 1 = hold PC.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, immediate): count=0, read and write pointers=0, all storage=0, outValid=0, pcOut=0, instrOut=0, notEnable=0. Reset asserted mid-operation drops all entries with no partial update.
- Storage: DEPTH-entry circular buffer, write pointer and read pointer each log2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is held in a separate counter, so full and empty are unambiguous.
- Combinational outputs:
  - outValid = (count != 0).
  - pcOut/instrOut = entry at the read pointer when outValid=1; 0 when empty.
  - deq = outValid & deqReady.
  - full = (count == DEPTH).
  - notEnable = full & ~deqReady.
- Enqueue: enq = inValid & (~full | deq) & ~flush. On the falling edge, write {pcIn, instrIn} at the write pointer and increment it.
- Dequeue: on the falling edge with deq & ~flush, increment the read pointer.
- Count update: +1 on enq only, -1 on deq only, unchanged when both occur.
- Full boundary: simultaneous enq and deq while full is legal. Occupancy stays DEPTH and both pointers advance.
- Empty boundary: an enqueue into an empty queue becomes visible on pcOut/instrOut after the same falling edge; there is no bypass from pcIn to pcOut in the same cycle. deqReady while empty has no effect.
- inValid=1 while full and deqReady=0: the entry is not written. notEnable=1 guarantees the PC register holds, so the same fetch is re-presented.
- Flush has priority over everything:
  - On the falling edge with flush=1, count and both pointers go to 0 and any same-cycle enq/deq is ignored.
  - Stored data need not be cleared, but outputs read 0 via the empty rule.
  - notEnable follows the combinational rule during the flush cycle and is 0 on the following cycle.
- Latency: 1 falling edge from inValid to outValid. Throughput: 1 entry per cycle in and out.

Test Plan:
1. Reset/basic: assert reset asynchronously between edges -> count=0, outValid=0, pcOut=0, notEnable=0 immediately. Release, enqueue pc=0x10 instr=0xDEADBEEF with deqReady=0 -> after one falling edge: outValid=1, pcOut=0x10, instrOut=0xDEADBEEF, count=1.
2. Fill to full: enqueue pc=0x00..0x03 with deqReady=0 -> count=4, notEnable=1. Present pc=0x04 -> not stored, count stays 4. Raise deqReady -> notEnable drops to 0 in the same cycle.
3. Full pass-through: with the queue full (0x00..0x03), hold inValid=1 pc=0x04 and deqReady=1 for one edge -> count=4, pcOut=0x01. Drain -> sequence 0x01,0x02,0x03,0x04.
4. Wrap-around: stream 10 entries pc=0x20..0x29 with deqReady=1 every cycle -> decode sees 0x20..0x29 in order with none lost or duplicated; count never exceeds 1.
5. Flush: with count=3, assert flush together with inValid=1 pc=0x50 and deqReady=1 -> after the edge count=0, outValid=0. Next enqueue pc=0x60 -> pcOut=0x60, count=1.
6. Reset mid-stream: with count=2 and an enqueue pending, assert reset before the edge -> count=0, outValid=0. After release, the first entry enqueued appears first and no stale entry emerges.
